// File: rtl/fb_pkg.sv
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared definitions for the framebuffer port arbiter slice.
//            Holds the framebuffer geometry, the default address and colour
//            widths, the clear-engine state encoding and the pixel-write
//            record used between the clear engine and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam int FB_W      = 640;
    localparam int FB_H      = 480;
    localparam int FB_PIXELS = FB_W * FB_H;
    localparam int ADDR_W    = 19;
    localparam int COLOR_W   = 6;

    // Clear engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // One pixel write: target address and colour
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pix_wr_t;

endpackage : fb_pkg

`default_nettype wire

// File: rtl/fb_port_arbiter_if.sv
// ============================================================================
// Module   : fb_port_arbiter_if
// Purpose  : Bundles every request/response and RAM-side signal of the
//            framebuffer port arbiter.
//   slave  modport : the arbiter side (takes requests, drives the RAM port)
//   master modport : the environment side (display, rasterizer, clear
//                    command, RAM model)
// Signals:
//   disp_req/disp_addr      display read request and address
//   disp_rdata/disp_rvalid  display read data and its valid strobe
//   rast_wen/addr/din       rasterizer write request, held until rast_ready
//   rast_ready              write accepted this cycle
//   clr_start/clr_color     clear command and fill colour
//   clr_busy/clr_done       clear in progress / one-cycle completion pulse
//   mem_addr/din/we/dout    single synchronous RAM port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fb_port_arbiter_if #(
    parameter int ADDR_W  = fb_pkg::ADDR_W,
    parameter int COLOR_W = fb_pkg::COLOR_W
);
    logic               disp_req;
    logic [ADDR_W-1:0]  disp_addr;
    logic [COLOR_W-1:0] disp_rdata;
    logic               disp_rvalid;

    logic               rast_wen;
    logic [ADDR_W-1:0]  rast_addr;
    logic [COLOR_W-1:0] rast_din;
    logic               rast_ready;

    logic               clr_start;
    logic [COLOR_W-1:0] clr_color;
    logic               clr_busy;
    logic               clr_done;

    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_din;
    logic               mem_we;
    logic [COLOR_W-1:0] mem_dout;

    modport slave (
        input  disp_req, disp_addr,
        output disp_rdata, disp_rvalid,
        input  rast_wen, rast_addr, rast_din,
        output rast_ready,
        input  clr_start, clr_color,
        output clr_busy, clr_done,
        output mem_addr, mem_din, mem_we,
        input  mem_dout
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_rdata, disp_rvalid,
        output rast_wen, rast_addr, rast_din,
        input  rast_ready,
        output clr_start, clr_color,
        input  clr_busy, clr_done,
        input  mem_addr, mem_din, mem_we,
        output mem_dout
    );

endinterface : fb_port_arbiter_if

`default_nettype wire

// File: rtl/fb_clear_engine.sv
// ============================================================================
// Module   : fb_clear_engine
// Purpose  : Fills the whole framebuffer with one colour on command.
//            A start pulse in IDLE latches the colour and begins a linear
//            sweep from address 0. Each cycle the arbiter grants the port,
//            one pixel is written and the address advances; ungranted
//            cycles simply stall the sweep. After the last pixel the engine
//            spends one cycle in DONE (done pulse) and returns to IDLE.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   start       clear command, honoured only in IDLE
//   color       fill colour, latched with an accepted start
//   grant       the RAM port is ours this cycle (no display read)
//   wr          current pixel write (address + colour)
//   req         a write is pending this cycle
//   busy        clear in progress
//   done        one-cycle pulse after the final write
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int FB_PIXELS = fb_pkg::FB_PIXELS
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               start,
    input  wire logic [COLOR_W-1:0] color,
    input  wire logic               grant,
    output pix_wr_t                 wr,
    output logic                    req,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

    clr_state_t         r_state;
    logic [ADDR_W-1:0]  r_cnt;
    logic [COLOR_W-1:0] r_color;
    logic               r_busy;
    logic               r_done;

    // State, counter, colour and the busy/done flags all move together so
    // the flags are registered views of the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_color <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_color <= color;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (grant) begin
                        if (r_cnt == c_LAST_ADDR) begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wr.addr  = r_cnt;
    assign wr.color = r_color;
    assign req      = r_busy;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule : fb_clear_engine

`default_nettype wire

// File: rtl/fb_port_arbiter.sv
// ============================================================================
// Module   : fb_port_arbiter
// Purpose  : Single-port framebuffer arbiter between display scan-out reads,
//            rasterizer pixel writes and the internal clear engine.
//            Priority per cycle: display read > clear write > rasterizer
//            write. Clear and rasterizer never share a cycle: while a clear
//            runs the rasterizer is held off via rast_ready.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus         fb_port_arbiter_if.slave (display, rasterizer, clear
//               command and RAM port signals)
//   rast_stall_cnt, clr_cycles (only with FB_PORT_ARBITER_PERF_EN):
//               saturating count of stalled rasterizer cycles, and the
//               length in cycles of the last completed clear.
// Build option:
//   FB_PORT_ARBITER_PERF_EN  adds the two performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int FB_PIXELS = fb_pkg::FB_PIXELS,
    parameter int ADDR_W    = fb_pkg::ADDR_W,
    parameter int COLOR_W   = fb_pkg::COLOR_W,
    parameter int RD_LAT    = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    fb_port_arbiter_if.slave        bus
`ifdef FB_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]             rast_stall_cnt,
    output logic [31:0]             clr_cycles
`endif
);

    // One extra bit so FB_PIXELS itself is representable for the range check
    localparam logic [ADDR_W:0] c_PIXELS_EXT = (ADDR_W + 1)'(FB_PIXELS);

    pix_wr_t            w_clr_wr;
    logic               w_clr_req;
    logic               w_clr_busy;
    logic               w_clr_done;
    logic               w_rast_ready;
    logic               w_rast_in_range;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [COLOR_W-1:0] w_mem_din;
    logic               w_mem_we;
    logic [RD_LAT-1:0]  r_rvalid;

    // ------------------------------------------------------------------
    // Clear engine: only advances on cycles without a display read
    // ------------------------------------------------------------------
    fb_clear_engine #(
        .FB_PIXELS (FB_PIXELS)
    ) u_clear (
        .clk   (clk),
        .reset (reset),
        .start (bus.clr_start),
        .color (bus.clr_color),
        .grant (!bus.disp_req),
        .wr    (w_clr_wr),
        .req   (w_clr_req),
        .busy  (w_clr_busy),
        .done  (w_clr_done)
    );

    // ------------------------------------------------------------------
    // Grant mux
    // ------------------------------------------------------------------
    assign w_rast_ready    = !bus.disp_req && !w_clr_busy;
    assign w_rast_in_range = ({1'b0, bus.rast_addr} < c_PIXELS_EXT);

    always_comb begin
        w_mem_addr = bus.disp_addr;
        w_mem_din  = bus.rast_din;
        w_mem_we   = 1'b0;
        if (bus.disp_req) begin
            w_mem_addr = bus.disp_addr;
        end else if (w_clr_req) begin
            w_mem_addr = ADDR_W'(w_clr_wr.addr);
            w_mem_din  = COLOR_W'(w_clr_wr.color);
            w_mem_we   = 1'b1;
        end else if (bus.rast_wen) begin
            // Out-of-range writes are accepted but never reach the RAM
            w_mem_addr = bus.rast_addr;
            w_mem_din  = bus.rast_din;
            w_mem_we   = w_rast_in_range;
        end
        // The RAM must never see a write while reset is held
        if (reset) begin
            w_mem_we = 1'b0;
        end
    end

    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_din    = w_mem_din;
    assign bus.mem_we     = w_mem_we;
    assign bus.rast_ready = w_rast_ready;
    assign bus.clr_busy   = w_clr_busy;
    assign bus.clr_done   = w_clr_done;

    // ------------------------------------------------------------------
    // Read-valid pipeline: tracks the RAM read latency
    // ------------------------------------------------------------------
    generate
        if (RD_LAT == 1) begin : g_rd_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rvalid <= '0;
                end else begin
                    r_rvalid <= bus.disp_req;
                end
            end
        end else begin : g_rd_latn
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rvalid <= '0;
                end else begin
                    r_rvalid <= {r_rvalid[RD_LAT-2:0], bus.disp_req};
                end
            end
        end
    endgenerate

    assign bus.disp_rvalid = r_rvalid[RD_LAT-1];
    assign bus.disp_rdata  = bus.mem_dout;

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef FB_PORT_ARBITER_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_clr_run;
    logic [31:0] r_clr_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_clr_run    <= '0;
            r_clr_cycles <= '0;
        end else begin
            if (bus.rast_wen && !w_rast_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            // Count every CLEAR cycle; publish and rearm when DONE is seen
            if (w_clr_busy) begin
                r_clr_run <= r_clr_run + 32'd1;
            end else if (w_clr_done) begin
                r_clr_cycles <= r_clr_run;
                r_clr_run    <= '0;
            end
        end
    end

    assign rast_stall_cnt = r_stall_cnt;
    assign clr_cycles     = r_clr_cycles;
`endif

endmodule : fb_port_arbiter

`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
// ============================================================================
// Module   : tb_fb_port_arbiter
// Purpose  : Self-checking bench for fb_port_arbiter with a reduced
//            framebuffer. Stimulus pushes expected RAM writes and display
//            read data into queues; a negedge monitor pops and compares
//            whenever the DUT writes the RAM or presents read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_port_arbiter;

    localparam int FBP     = 64;
    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 6;
    localparam int RD_LAT  = 1;

    typedef struct {
        int           addr;
        logic [5:0]   data;
    } wr_exp_t;

    typedef struct {
        bit           care;
        logic [5:0]   data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fb_port_arbiter_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

`ifdef FB_PORT_ARBITER_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] clr_cyc;
`endif

    fb_port_arbiter #(
        .FB_PIXELS (FBP),
        .ADDR_W    (ADDR_W),
        .COLOR_W   (COLOR_W),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef FB_PORT_ARBITER_PERF_EN
        ,
        .rast_stall_cnt (stall_cnt),
        .clr_cycles     (clr_cyc)
`endif
    );

    // ---------------- RAM model (environment) ----------------
    logic [5:0] ram [0:FBP-1];
    logic [5:0] rd_pipe [RD_LAT];
    logic [5:0] ram_i;
    logic       ram_ok;
    assign ram_i  = bus.mem_addr[5:0];
    assign ram_ok = (bus.mem_addr < 19'(FBP));

    always @(posedge clk) begin
        if (bus.mem_we && ram_ok) ram[ram_i] <= bus.mem_din;
        rd_pipe[0] <= ram_ok ? ram[ram_i] : 6'h00;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_dout = rd_pipe[RD_LAT-1];

    // ---------------- Reference model ----------------
    logic [5:0] ref_mem [0:FBP-1];
    wr_exp_t    wq[$];
    rd_exp_t    rq[$];
    bit         m_clearing;
    int         m_next;
    logic [5:0] m_col;
    bit         m_done_now;
    int         m_stall;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_we) chk("we_in_reset", 32'(bus.mem_we), 32'd0);
        end else begin
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_addr", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(bus.mem_din), 32'(e.data));
                end
            end
            if (bus.disp_rvalid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    rd_exp_t e;
                    e = rq.pop_front();
                    if (e.care) chk("rd_data", 32'(bus.disp_rdata), 32'(e.data));
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input bit dreq, input int daddr, input bit rw, input int raddr,
                         input logic [5:0] rdin, input bit cs, input logic [5:0] cc,
                         output bit accepted);
        bit exp_ready, exp_busy, exp_done, start_ok, next_done;
        rd_exp_t r;
        bus.disp_req  = dreq;
        bus.disp_addr = 19'(daddr);
        bus.rast_wen  = rw;
        bus.rast_addr = 19'(raddr);
        bus.rast_din  = rdin;
        bus.clr_start = cs;
        bus.clr_color = cc;

        exp_ready = !dreq && !m_clearing;
        exp_busy  = m_clearing;
        exp_done  = m_done_now;
        start_ok  = cs && !m_clearing && !m_done_now;
        next_done = 1'b0;
        if (rw && !exp_ready) m_stall++;

        if (dreq) begin
            r.care = (daddr < FBP);
            r.data = r.care ? ref_mem[daddr] : 6'h00;
            rq.push_back(r);
        end else if (m_clearing) begin
            wq.push_back('{m_next, m_col});
            ref_mem[m_next] = m_col;
            m_next++;
            if (m_next == FBP) begin
                m_clearing = 1'b0;
                next_done  = 1'b1;
            end
        end else if (rw && raddr < FBP) begin
            wq.push_back('{raddr, rdin});
            ref_mem[raddr] = rdin;
        end
        if (start_ok) begin
            m_clearing = 1'b1;
            m_next     = 0;
            m_col      = cc;
        end
        m_done_now = next_done;
        accepted   = rw && exp_ready;

        @(negedge clk);
        chk("rast_ready", 32'(bus.rast_ready), 32'(exp_ready));
        chk("clr_busy",   32'(bus.clr_busy),   32'(exp_busy));
        chk("clr_done",   32'(bus.clr_done),   32'(exp_done));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.rast_wen  = 1'b0;
        bus.rast_addr = '0;
        bus.rast_din  = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset      = 1'b1;
        m_clearing = 1'b0;
        m_done_now = 1'b0;
        m_next     = 0;
        m_stall    = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(bus.clr_busy),    32'd0);
        chk("rst_done",   32'(bus.clr_done),    32'd0);
        chk("rst_rvalid", 32'(bus.disp_rvalid), 32'd0);
        chk("rst_we",     32'(bus.mem_we),      32'd0);
        reset = 1'b0;
    endtask

    bit         r_rw;
    int         r_addr;
    logic [5:0] r_din;

    task automatic new_rast();
        r_rw   = ($urandom_range(0, 2) != 0);
        r_addr = $urandom_range(0, FBP + 3);
        r_din  = 6'($urandom);
    endtask

    initial begin
        bit acc;
        for (int i = 0; i < FBP; i++) begin
            ram[i]     = 6'h00;
            ref_mem[i] = 6'h00;
        end
        m_col = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Single in-range rasterizer write
        cycle(0, 0, 1, 10, 6'h2A, 0, 0, acc);
        chk("t1_accept", 32'(acc), 32'd1);

        // Display holds the port for 3 cycles, write lands on the 4th
        for (int i = 0; i < 3; i++) cycle(1, 5, 1, 20, 6'h11, 0, 0, acc);
        cycle(0, 0, 1, 20, 6'h11, 0, 0, acc);

        // Out-of-range write dropped, then last valid address written
        cycle(0, 0, 1, FBP, 6'h3F, 0, 0, acc);
        cycle(0, 0, 1, FBP - 1, 6'h07, 0, 0, acc);
        cycle(1, FBP - 1, 0, 0, 0, 0, 0, acc);
        cycle(1, 10, 0, 0, 0, 0, 0, acc);

        // Full clear without display traffic, rasterizer asking throughout
        cycle(0, 0, 0, 0, 0, 1, 6'h15, acc);
        for (int i = 0; i < FBP + 4; i++) cycle(0, 0, 1, 3, 6'h01, (i == 5), 6'h2B, acc);
        for (int i = 0; i < FBP; i++) cycle(1, i, 0, 0, 0, 0, 0, acc);

        // Clear with a burst of display reads in the middle
        cycle(0, 0, 0, 0, 0, 1, 6'h0C, acc);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 0, 0, acc);
        for (int i = 0; i < 10; i++) cycle(1, $urandom_range(0, FBP + 2), 0, 0, 0, 0, 0, acc);
        for (int i = 0; i < FBP; i++) cycle(0, 0, 0, 0, 0, 0, 0, acc);

        // Reset in the middle of a clear, then restart from address 0
        cycle(0, 0, 0, 0, 0, 1, 6'h33, acc);
        for (int i = 0; i < 30; i++) cycle(0, 0, 0, 0, 0, 0, 0, acc);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, 1, 6'h2D, acc);
        for (int i = 0; i < FBP + 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, acc);

        // Randomised traffic with a rasterizer that holds until accepted
        new_rast();
        for (int i = 0; i < 1500; i++) begin
            bit dreq, cs;
            dreq = ($urandom_range(0, 2) == 0);
            cs   = ($urandom_range(0, 60) == 0);
            cycle(dreq, $urandom_range(0, FBP + 3), r_rw, r_addr, r_din,
                  cs, 6'($urandom), acc);
            if (acc || !r_rw) new_rast();
        end

        // Wait (bounded) for any clear to finish, then read everything back
        for (int i = 0; i < FBP + 50 && (m_clearing || m_done_now); i++)
            cycle(0, 0, 0, 0, 0, 0, 0, acc);
        for (int i = 0; i < FBP; i++) cycle(1, i, 0, 0, 0, 0, 0, acc);
        for (int i = 0; i < RD_LAT + 2; i++) cycle(0, 0, 0, 0, 0, 0, 0, acc);
        chk("clear_finished", 32'(m_clearing), 32'd0);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
`ifdef FB_PORT_ARBITER_PERF_EN
        chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fb_port_arbiter

`default_nettype wire
